// File: rtl/mod_check_pkg.sv
// ============================================================================
// Module   : mod_check_pkg
// Purpose  : Shared definitions for the sequential modulo checker: the
//            controller state encoding and a helper that sizes the bit
//            counter for a given dividend width.
// Ports    : none (package)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_check_pkg;

   // Controller states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Bits needed for a down-counter that starts at n-1 and ends at 0.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : mod_check_pkg

`default_nettype wire

// File: rtl/mod_check_step.sv
// ============================================================================
// Module   : mod_check_step
// Purpose  : One combinational restoring shift-subtract step. Shifts the next
//            dividend bit into the partial remainder and subtracts the divisor
//            when it fits.
// Ports    : r_i    - current partial remainder (DW bits)
//            bit_i  - next dividend bit (MSB first)
//            div_i  - divisor (DW bits, nonzero while in use)
//            r_o    - updated partial remainder (DW bits)
//            q_o    - quotient bit of this step (MOD_CHECK_QUOT_EN only)
// Options  : MOD_CHECK_QUOT_EN - exposes the quotient bit output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_check_step #(
   parameter int DW = 4
) (
   input  logic [DW-1:0] r_i,
   input  logic          bit_i,
   input  logic [DW-1:0] div_i,
`ifdef MOD_CHECK_QUOT_EN
   output logic          q_o,
`endif
   output logic [DW-1:0] r_o
);

   logic [DW:0] w_shift;
   logic        w_ge;

   // The shifted value is DW+1 bits so the compare never overflows.
   assign w_shift = {r_i, bit_i};
   assign w_ge    = (w_shift >= {1'b0, div_i});

   // When the subtraction is taken the difference is below the divisor and
   // therefore fits in DW bits, so only the low DW bits need computing.
   // When it is not taken the shifted value is already below the divisor.
   assign r_o = w_ge ? (w_shift[DW-1:0] - div_i) : w_shift[DW-1:0];

`ifdef MOD_CHECK_QUOT_EN
   assign q_o = w_ge;
`endif

endmodule : mod_check_step

`default_nettype wire

// File: rtl/mod_check_seq.sv
// ============================================================================
// Module   : mod_check_seq
// Purpose  : Sequential divisibility / modulo checker. Accepts a WIDTH-bit
//            dividend and a DW-bit runtime divisor over a valid/ready
//            handshake, computes the remainder one dividend bit per cycle
//            with a restoring shift-subtract step and presents remainder,
//            divisible flag and divide-by-zero error on a second handshake.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid/in_ready - request handshake
//            data_in, div_in   - dividend / divisor, captured on accept
//            out_valid/out_ready - result handshake
//            remainder         - data_in mod div_in
//            divisible         - remainder==0 and div_in!=0
//            div_err           - div_in==0
//            quotient          - floor(data_in/div_in) (MOD_CHECK_QUOT_EN)
// Options  : MOD_CHECK_QUOT_EN - adds the quotient output and its register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_check_seq
   import mod_check_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [DW-1:0]    div_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    remainder,
   output logic             divisible,
`ifdef MOD_CHECK_QUOT_EN
   output logic [WIDTH-1:0] quotient,
`endif
   output logic             div_err
);

   localparam int c_cnt_w = cnt_width(WIDTH);

   state_e             state_q,     state_d;
   logic [c_cnt_w-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0]   dividend_q,  dividend_d;
   logic [DW-1:0]      divisor_q,   divisor_d;
   logic [DW-1:0]      part_q,      part_d;
   logic [DW-1:0]      remainder_q, remainder_d;
   logic               divisible_q, divisible_d;
   logic               div_err_q,   div_err_d;
`ifdef MOD_CHECK_QUOT_EN
   logic [WIDTH-1:0]   q_q,         q_d;
   logic [WIDTH-1:0]   quotient_q,  quotient_d;
   logic               w_qbit;
`endif

   logic [DW-1:0]      w_step_r;

   // Single step instance, iterated over time by the bit counter.
   mod_check_step #(
      .DW    (DW)
   ) u_step (
      .r_i   (part_q),
      .bit_i (dividend_q[cnt_q]),
      .div_i (divisor_q),
`ifdef MOD_CHECK_QUOT_EN
      .q_o   (w_qbit),
`endif
      .r_o   (w_step_r)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dividend_d  = dividend_q;
      divisor_d   = divisor_q;
      part_d      = part_q;
      remainder_d = remainder_q;
      divisible_d = divisible_q;
      div_err_d   = div_err_q;
`ifdef MOD_CHECK_QUOT_EN
      q_d         = q_q;
      quotient_d  = quotient_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               dividend_d = data_in;
               divisor_d  = div_in;
               part_d     = '0;
`ifdef MOD_CHECK_QUOT_EN
               q_d        = '0;
`endif
               if (div_in == '0) begin
                  // Zero divisor: skip the iteration entirely and report
                  // the error in the cycle right after the accept edge.
                  state_d     = ST_DONE;
                  remainder_d = '0;
                  divisible_d = 1'b0;
                  div_err_d   = 1'b1;
`ifdef MOD_CHECK_QUOT_EN
                  quotient_d  = '0;
`endif
               end else begin
                  state_d = ST_RUN;
                  cnt_d   = c_cnt_w'(WIDTH - 1);
               end
            end
         end

         ST_RUN: begin
            part_d = w_step_r;
`ifdef MOD_CHECK_QUOT_EN
            q_d[cnt_q] = w_qbit;
`endif
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               // Last dividend bit: the step output is the final remainder.
               state_d     = ST_DONE;
               remainder_d = w_step_r;
               divisible_d = (w_step_r == '0);
               div_err_d   = 1'b0;
`ifdef MOD_CHECK_QUOT_EN
               quotient_d  = q_d;
`endif
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dividend_q  <= '0;
         divisor_q   <= '0;
         part_q      <= '0;
         remainder_q <= '0;
         divisible_q <= 1'b0;
         div_err_q   <= 1'b0;
`ifdef MOD_CHECK_QUOT_EN
         q_q         <= '0;
         quotient_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         part_q      <= part_d;
         remainder_q <= remainder_d;
         divisible_q <= divisible_d;
         div_err_q   <= div_err_d;
`ifdef MOD_CHECK_QUOT_EN
         q_q         <= q_d;
         quotient_q  <= quotient_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign remainder = remainder_q;
   assign divisible = divisible_q;
   assign div_err   = div_err_q;
`ifdef MOD_CHECK_QUOT_EN
   assign quotient  = quotient_q;
`endif

endmodule : mod_check_seq

`default_nettype wire

// File: tb/tb_mod_check_seq.sv
// ============================================================================
// Module   : tb_mod_check_seq
// Purpose  : Directed self-checking bench for mod_check_seq. Instantiates a
//            default (WIDTH=8, DW=4) block and a small (WIDTH=4, DW=3) block
//            sharing clock and reset.
// Options  : MOD_CHECK_QUOT_EN - also checks the quotient outputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_check_seq;

   logic       clk;
   logic       rst;

   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] data_in;
   logic [3:0] div_in, remainder;
   logic       divisible, div_err;
   logic [7:0] quotient;

   logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [3:0] s_data_in;
   logic [2:0] s_div_in, s_remainder;
   logic       s_divisible, s_div_err;
   logic [3:0] s_quotient;

   int n_checks = 0;
   int n_pass   = 0;

   mod_check_seq #(.WIDTH(8), .DW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .div_in    (div_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .remainder (remainder),
      .divisible (divisible),
`ifdef MOD_CHECK_QUOT_EN
      .quotient  (quotient),
`endif
      .div_err   (div_err)
   );

   mod_check_seq #(.WIDTH(4), .DW(3)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .data_in   (s_data_in),
      .div_in    (s_div_in),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .remainder (s_remainder),
      .divisible (s_divisible),
`ifdef MOD_CHECK_QUOT_EN
      .quotient  (s_quotient),
`endif
      .div_err   (s_div_err)
   );

`ifndef MOD_CHECK_QUOT_EN
   assign quotient   = '0;
   assign s_quotient = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   // Present one request to the default block while it is idle, scramble the
   // inputs after the accept edge, and return the number of clock edges after
   // the accept edge until out_valid is seen (-1 if it never appears).
   task automatic run_req(input logic [7:0] d, input logic [3:0] v, output int edges);
      @(negedge clk);
      data_in  = d;
      div_in   = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      data_in  = ~d;
      div_in   = ~v;
      edges    = 0;
      while (!out_valid && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      if (!out_valid) edges = -1;
   endtask

   task automatic ack();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_req_s(input logic [3:0] d, input logic [2:0] v, output int edges);
      @(negedge clk);
      s_data_in  = d;
      s_div_in   = v;
      s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      s_data_in  = ~d;
      s_div_in   = ~v;
      edges      = 0;
      while (!s_out_valid && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      if (!s_out_valid) edges = -1;
      @(negedge clk);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b expected 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b expected 0", out_valid); else n_pass++;
      n_checks++; if (remainder !== 4'd0) $display("FAIL rst_remainder: got %0d expected 0", remainder); else n_pass++;
      n_checks++; if (divisible !== 1'b0) $display("FAIL rst_divisible: got %0b expected 0", divisible); else n_pass++;
      n_checks++; if (div_err !== 1'b0) $display("FAIL rst_div_err: got %0b expected 0", div_err); else n_pass++;
      n_checks++; if (s_in_ready !== 1'b1) $display("FAIL rst_s_in_ready: got %0b expected 1", s_in_ready); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int e;
      run_req(8'd12, 4'd4, e);
      n_checks++; if (e !== 8) $display("FAIL basic_latency: got %0d expected 8", e); else n_pass++;
      n_checks++; if (remainder !== 4'd0) $display("FAIL basic_rem: got %0d expected 0", remainder); else n_pass++;
      n_checks++; if (divisible !== 1'b1) $display("FAIL basic_divisible: got %0b expected 1", divisible); else n_pass++;
      n_checks++; if (div_err !== 1'b0) $display("FAIL basic_div_err: got %0b expected 0", div_err); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done: got %0b expected 0", in_ready); else n_pass++;
`ifdef MOD_CHECK_QUOT_EN
      n_checks++; if (quotient !== 8'd3) $display("FAIL basic_quot: got %0d expected 3", quotient); else n_pass++;
`endif
      ack();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_back_idle: got ready=%0b valid=%0b expected ready=1 valid=0", in_ready, out_valid); else n_pass++;
   endtask

   task automatic test_patterns();
      int e;
      // Each row: dividend, divisor, remainder, divisible, quotient.
      logic [7:0] t_d [6] = '{8'd1,  8'd255, 8'd0,  8'd7,  8'd255, 8'd254};
      logic [3:0] t_v [6] = '{4'd4,  4'd15,  4'd5,  4'd9,  4'd1,   4'd15};
      logic [3:0] t_r [6] = '{4'd1,  4'd0,   4'd0,  4'd7,  4'd0,   4'd14};
      logic       t_z [6] = '{1'b0,  1'b1,   1'b1,  1'b0,  1'b1,   1'b0};
      logic [7:0] t_q [6] = '{8'd0,  8'd17,  8'd0,  8'd0,  8'd255, 8'd16};
      for (int i = 0; i < 6; i++) begin
         run_req(t_d[i], t_v[i], e);
         n_checks++; if (e !== 8) $display("FAIL pat%0d_latency: got %0d expected 8", i, e); else n_pass++;
         n_checks++; if (remainder !== t_r[i]) $display("FAIL pat%0d_rem: got %0d expected %0d", i, remainder, t_r[i]); else n_pass++;
         n_checks++; if (divisible !== t_z[i]) $display("FAIL pat%0d_divisible: got %0b expected %0b", i, divisible, t_z[i]); else n_pass++;
`ifdef MOD_CHECK_QUOT_EN
         n_checks++; if (quotient !== t_q[i]) $display("FAIL pat%0d_quot: got %0d expected %0d", i, quotient, t_q[i]); else n_pass++;
`else
         if (t_q[i] == 8'hxx) $display("unreachable");
`endif
         ack();
      end
   endtask

   task automatic test_div_zero();
      int e;
      run_req(8'd77, 4'd0, e);
      n_checks++; if (e !== 0) $display("FAIL dz_latency: got %0d expected 0", e); else n_pass++;
      n_checks++; if (div_err !== 1'b1) $display("FAIL dz_div_err: got %0b expected 1", div_err); else n_pass++;
      n_checks++; if (divisible !== 1'b0) $display("FAIL dz_divisible: got %0b expected 0", divisible); else n_pass++;
      n_checks++; if (remainder !== 4'd0) $display("FAIL dz_rem: got %0d expected 0", remainder); else n_pass++;
`ifdef MOD_CHECK_QUOT_EN
      n_checks++; if (quotient !== 8'd0) $display("FAIL dz_quot: got %0d expected 0", quotient); else n_pass++;
`endif
      ack();
   endtask

   task automatic test_back_to_back();
      int e;
      run_req(8'd12, 4'd4, e);
      // Second request arrives while the first result is still unacknowledged.
      data_in  = 8'd100;
      div_in   = 4'd7;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold%0d_hs: got valid=%0b ready=%0b expected valid=1 ready=0", i, out_valid, in_ready); else n_pass++;
         n_checks++; if (remainder !== 4'd0 || divisible !== 1'b1) $display("FAIL hold%0d_result: got rem=%0d div=%0b expected rem=0 div=1", i, remainder, divisible); else n_pass++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_idle: got ready=%0b valid=%0b expected ready=1 valid=0", in_ready, out_valid); else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_accepted: got ready=%0b expected 0", in_ready); else n_pass++;
      e = 0;
      while (!out_valid && e < 40) begin
         @(negedge clk);
         e++;
      end
      n_checks++; if (e !== 8) $display("FAIL b2b_latency: got %0d expected 8", e); else n_pass++;
      n_checks++; if (remainder !== 4'd2 || divisible !== 1'b0) $display("FAIL b2b_result: got rem=%0d div=%0b expected rem=2 div=0", remainder, divisible); else n_pass++;
`ifdef MOD_CHECK_QUOT_EN
      n_checks++; if (quotient !== 8'd14) $display("FAIL b2b_quot: got %0d expected 14", quotient); else n_pass++;
`endif
      ack();
   endtask

   task automatic test_reset_mid_run();
      int e;
      run_req(8'd1, 4'd4, e);   // leaves remainder=1 on the outputs
      ack();
      @(negedge clk);
      data_in  = 8'd255;
      div_in   = 4'd15;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL mrst_hs: got ready=%0b valid=%0b expected ready=1 valid=0", in_ready, out_valid); else n_pass++;
      n_checks++; if (remainder !== 4'd0 || divisible !== 1'b0 || div_err !== 1'b0) $display("FAIL mrst_outputs: got rem=%0d div=%0b err=%0b expected 0 0 0", remainder, divisible, div_err); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      run_req(8'd200, 4'd9, e);
      n_checks++; if (e !== 8) $display("FAIL mrst_latency: got %0d expected 8", e); else n_pass++;
      n_checks++; if (remainder !== 4'd2 || divisible !== 1'b0) $display("FAIL mrst_result: got rem=%0d div=%0b expected rem=2 div=0", remainder, divisible); else n_pass++;
`ifdef MOD_CHECK_QUOT_EN
      n_checks++; if (quotient !== 8'd22) $display("FAIL mrst_quot: got %0d expected 22", quotient); else n_pass++;
`endif
      ack();
   endtask

   task automatic test_small_exhaustive();
      int e;
      logic [2:0] exp_r;
      logic [3:0] exp_q;
      logic       exp_z;
      for (int d = 0; d < 16; d++) begin
         for (int v = 1; v < 8; v++) begin
            exp_r = 3'(d % v);
            exp_q = 4'(d / v);
            exp_z = ((d % v) == 0);
            run_req_s(4'(d), 3'(v), e);
            n_checks++; if (e !== 4) $display("FAIL small_%0d_%0d_latency: got %0d expected 4", d, v, e); else n_pass++;
            n_checks++; if (s_remainder !== exp_r) $display("FAIL small_%0d_%0d_rem: got %0d expected %0d", d, v, s_remainder, exp_r); else n_pass++;
            n_checks++; if (s_divisible !== exp_z) $display("FAIL small_%0d_%0d_divisible: got %0b expected %0b", d, v, s_divisible, exp_z); else n_pass++;
`ifdef MOD_CHECK_QUOT_EN
            n_checks++; if (s_quotient !== exp_q) $display("FAIL small_%0d_%0d_quot: got %0d expected %0d", d, v, s_quotient, exp_q); else n_pass++;
`else
            if (exp_q === 4'bxxxx) $display("unreachable");
`endif
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      data_in     = '0;
      div_in      = '0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      s_data_in   = '0;
      s_div_in    = '0;

      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      test_small_exhaustive();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mod_check_seq

`default_nettype wire
